mem_wb_skid_fifo: RTL and testbench
===================================

// Module: mem_wb_skid_fifo
// PURPOSE
//  Elastic buffer between the memory-access stage and the write-back stage. It captures the
//  complete memory-stage result bundle in the exact cycle its handshake fires, including load
//  data that is only valid for that one cycle. It replays the bundle to write-back under
//  valid/ready. It also reports GPR read-after-write hits on buffered entries, for the decode
//  stage stall logic.
// PARAMETERS
//  DEPTH  2    entry count; power of two, >=2
//  PW     257  payload width; layout MSB->LSB: pc[32] npc[32] alu_result[32] sext_imm[32]
//              rs1_data[32] rdata_csr[32] mem_rdata[32] is_break[1] irq[1] irq_no[8]
//              gpr_we[1] csr_we[1] gpr_waddr[4] csr_waddr[12] gpr_rd[3] csr_rd[2]
// PORTS
//  clk         in   1          clock, rising edge
//  reset       in   1          asynchronous, active-low reset
//  in_valid    in   1          upstream valid; may be combinational from AXI R/B handshake
//  in_ready    out  1          buffer can accept
//  in_data     in   PW         upstream payload bundle
//  out_valid   out  1          head entry valid to write-back
//  out_ready   in   1          write-back accepts head
//  out_data    out  PW         head entry payload
//  flush       in   1          synchronous discard of all entries
//  count       out  $clog2(DEPTH+1)  occupied entries
//  rs1_addr    in   4          decode-stage source register 1
//  rs2_addr    in   4          decode-stage source register 2
//  raw_hit     out  1          a buffered entry will write rs1_addr or rs2_addr
// BEHAVIOUR
//  - Storage: circular array mem[DEPTH]; wr_ptr and rd_ptr are log2(DEPTH)-bit and wrap
//    naturally; count is tracked separately, so full and empty are unambiguous.
//  - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated on the same edge.
//  - in_ready = (count != DEPTH); it depends on registered state only. There is no
//    combinational path from in_valid or out_ready to in_ready.
//  - out_valid = (count != 0). out_data = mem[rd_ptr] when out_valid, else all zeros.
//  - Latency: an entry pushed at edge N is presented at out_data after edge N and is first
//    poppable at edge N+1. There is no same-cycle bypass.
//  - push only: mem[wr_ptr]<=in_data, wr_ptr++, count++.
//  - pop only: rd_ptr++, count--.
//  - push & pop together: both pointers advance, count unchanged. This is legal at any
//    count 0<count<DEPTH. At count==DEPTH push is blocked by in_ready=0, so only the pop
//    happens. At count==0 pop is impossible because out_valid=0.
//  - in_data is sampled only on the push edge. It is never re-read afterwards, because
//    upstream load data is only valid in that cycle.
//  - flush=1: on the next edge rd_ptr, wr_ptr and count go to 0. Flush has priority over a
//    simultaneous push and pop; both are dropped. in_ready stays as computed from the
//    pre-flush count that cycle.
//  - raw_hit is combinational. It is 1 if any occupied entry i has gpr_we=1,
//    gpr_waddr!=0, and gpr_waddr==rs1_addr or gpr_waddr==rs2_addr. An entry popping this
//    cycle still counts. Register x0 never hits. raw_hit=0 when count==0.
//  - Reset (reset==0, asynchronous): wr_ptr=0, rd_ptr=0, count=0.
//    Outputs in reset: in_ready=1, out_valid=0, out_data=0, raw_hit=0.
//    Storage contents are not reset; they are masked by count.
//    Reset asserted mid-transfer discards every entry with no partial output.
//  - Release of reset is synchronized externally; first push is legal on the first edge
//    after release.
// TESTING
//  1. Single push of pc=0x8000_0000, mem_rdata=0xDEAD_BEEF with out_ready=1 ->
//     out_valid rises the cycle after the push, out_data fields match, pops next edge,
//     count 0->1->0.
//  2. Back-to-back pushes with out_ready=0 and DEPTH=2 -> count=2, in_ready=0; a third
//     in_valid is not accepted; raising out_ready drains entries in push order.
//  3. Steady stream of 8 pushes with out_ready=1 every cycle -> count stays at 1,
//     pointers wrap, all 8 pc values emerge in order, no drop or duplicate.
//  4. Entry with gpr_we=1, gpr_waddr=5 buffered:
//     - rs1_addr=5 -> raw_hit=1.
//     - gpr_waddr=0 -> raw_hit=0.
//     - gpr_we=0 -> raw_hit=0.
//     - After that entry pops -> raw_hit=0.
//  5. flush=1 with count=2 and in_valid=1 in the same cycle -> next cycle count=0,
//     out_valid=0, and the pushed payload never appears at out_data.
//  6. Drive reset low while count=1 mid-stream -> out_valid=0, out_data=0, in_ready=1
//     immediately (asynchronous); after release the first push behaves as in test 1.

Source files
------------

// File: rtl/mem_wb_skid_fifo_if.sv
// Valid/ready/payload bundle used on both sides of the MEM->WB buffer.
// master drives valid+data and samples ready; slave is the reverse.
interface mem_wb_skid_fifo_if #(
   parameter int PW = 257
);
   logic          valid;
   logic          ready;
   logic [PW-1:0] data;

   modport master (
      output valid,
      output data,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      output ready
   );
endinterface

// File: rtl/mem_wb_skid_fifo.sv
// Elastic MEM->WB buffer: captures the result bundle on the push edge,
// replays it under valid/ready, and flags GPR RAW hits for decode.
// Ports: clk, reset (async, active-low), s_in (slave: in_valid/in_ready/
// in_data), m_out (master: out_valid/out_ready/out_data), flush, count,
// rs1_addr, rs2_addr, raw_hit.
module mem_wb_skid_fifo #(
   parameter int DEPTH = 2,
   parameter int PW    = 257
) (
   input  logic                       clk,
   input  logic                       reset,
   mem_wb_skid_fifo_if.slave          s_in,
   mem_wb_skid_fifo_if.master         m_out,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   input  logic [3:0]                 rs1_addr,
   input  logic [3:0]                 rs2_addr,
   output logic                       raw_hit
);
   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = $clog2(DEPTH+1);
   localparam int GPR_WE = 22;
   localparam int GPR_WA = 17;

   logic [PW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_ready;
   logic          w_valid;
   logic          w_push;
   logic          w_pop;
   logic          w_hit;
   logic [AW-1:0] w_off;
   logic [3:0]    w_wa;

   // Ready comes from registered count only: no in_valid/out_ready path.
   assign w_ready = (r_count != CW'(DEPTH));
   assign w_valid = (r_count != '0);
   assign w_push  = s_in.valid & w_ready;
   assign w_pop   = w_valid & m_out.ready;

   assign s_in.ready  = w_ready;
   assign m_out.valid = w_valid;
   assign m_out.data  = w_valid ? r_mem[r_rd_ptr] : '0;
   assign count       = r_count;
   assign raw_hit     = w_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage is never reset; occupancy masks stale entries.
   always_ff @(posedge clk) begin
      if (w_push && !flush)
         r_mem[r_wr_ptr] <= s_in.data;
   end

   // Entry i is occupied when its distance from rd_ptr is below count.
   always_comb begin
      w_hit = 1'b0;
      w_off = '0;
      w_wa  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_off = AW'(i) - r_rd_ptr;
         w_wa  = r_mem[i][GPR_WA +: 4];
         if ((CW'(w_off) < r_count) &&
             r_mem[i][GPR_WE] &&
             (w_wa != 4'd0) &&
             ((w_wa == rs1_addr) || (w_wa == rs2_addr)))
            w_hit = 1'b1;
      end
   end
endmodule

// File: tb/tb_mem_wb_skid_fifo.sv
// Bench for mem_wb_skid_fifo: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_mem_wb_skid_fifo;
   localparam int PW = 257;

   logic       clk;
   logic       reset;
   logic       flush;
   logic [1:0] count;
   logic [3:0] rs1_addr;
   logic [3:0] rs2_addr;
   logic       raw_hit;

   int n_chk  = 0;
   int n_fail = 0;

   mem_wb_skid_fifo_if #(.PW(PW)) u_in ();
   mem_wb_skid_fifo_if #(.PW(PW)) u_out ();

   mem_wb_skid_fifo #(
      .DEPTH(2),
      .PW   (PW)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .s_in    (u_in.slave),
      .m_out   (u_out.master),
      .flush   (flush),
      .count   (count),
      .rs1_addr(rs1_addr),
      .rs2_addr(rs2_addr),
      .raw_hit (raw_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        iv;
      logic [31:0] pc;
      logic [31:0] rd;
      logic        we;
      logic [3:0]  wa;
      logic        ordy;
      logic        fl;
      logic [3:0]  r1;
      logic [3:0]  r2;
      logic [1:0]  e_cnt;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_pc;
      logic [31:0] e_rd;
      logic        e_hit;
   } vec_t;

   vec_t tv [18];

   function automatic vec_t mkv(
      logic iv, logic [31:0] pc, logic [31:0] rd,
      logic we, logic [3:0] wa, logic ordy, logic fl,
      logic [3:0] r1, logic [3:0] r2,
      logic [1:0] ec, logic eov, logic eir,
      logic [31:0] epc, logic [31:0] erd, logic eh);
      vec_t v;
      v.iv = iv; v.pc = pc; v.rd = rd; v.we = we; v.wa = wa;
      v.ordy = ordy; v.fl = fl; v.r1 = r1; v.r2 = r2;
      v.e_cnt = ec; v.e_ov = eov; v.e_ir = eir;
      v.e_pc = epc; v.e_rd = erd; v.e_hit = eh;
      return v;
   endfunction

   function automatic logic [PW-1:0] mk(
      logic [31:0] pc, logic [31:0] rd, logic we, logic [3:0] wa);
      logic [PW-1:0] p;
      p = '0;
      p[256:225] = pc;
      p[224:193] = pc + 32'd4;
      p[64:33]   = rd;
      p[22]      = we;
      p[20:17]   = wa;
      return p;
   endfunction

   function automatic logic [PW-1:0] rnd_pl();
      logic [287:0] t;
      for (int k = 0; k < 9; k++)
         t[k*32 +: 32] = $urandom();
      t[20:17] = 4'($urandom_range(0, 3));
      return t[PW-1:0];
   endfunction

   task automatic chk(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle_in();
      u_in.valid   = 1'b0;
      u_in.data    = '0;
      u_out.ready  = 1'b0;
      flush        = 1'b0;
      rs1_addr     = 4'd0;
      rs2_addr     = 4'd0;
   endtask

   logic [PW-1:0] q [$];
   logic          e_ir;
   logic          e_ov;
   logic          e_hit;
   logic [PW-1:0] e_od;
   logic          pv;
   logic          pp;

   initial begin
      // ---- table: tests 1, 2, 4, 5 and push+pop at count 1 ----
      tv[0]  = mkv(1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 4'd0, 1'b1, 1'b0,
                   4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
      tv[1]  = mkv(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0,
                   4'd0, 4'd0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      tv[2]  = mkv(1'b1, 32'h100, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0,
                   4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 32'h100, 32'h0, 1'b0);
      tv[3]  = mkv(1'b1, 32'h104, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0,
                   4'd0, 4'd0, 2'd2, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
      tv[4]  = mkv(1'b1, 32'h108, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0,
                   4'd0, 4'd0, 2'd2, 1'b1, 1'b0, 32'h100, 32'h0, 1'b0);
      tv[5]  = mkv(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0,
                   4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 32'h104, 32'h0, 1'b0);
      tv[6]  = mkv(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0,
                   4'd0, 4'd0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      tv[7]  = mkv(1'b1, 32'h200, 32'h0, 1'b1, 4'd5, 1'b0, 1'b0,
                   4'd5, 4'd0, 2'd1, 1'b1, 1'b1, 32'h200, 32'h0, 1'b1);
      tv[8]  = mkv(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0,
                   4'd5, 4'd0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      tv[9]  = mkv(1'b1, 32'h210, 32'h0, 1'b1, 4'd0, 1'b0, 1'b0,
                   4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 32'h210, 32'h0, 1'b0);
      tv[10] = mkv(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0,
                   4'd0, 4'd0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      tv[11] = mkv(1'b1, 32'h220, 32'h0, 1'b0, 4'd5, 1'b0, 1'b0,
                   4'd5, 4'd5, 2'd1, 1'b1, 1'b1, 32'h220, 32'h0, 1'b0);
      tv[12] = mkv(1'b1, 32'h224, 32'h0, 1'b1, 4'd7, 1'b0, 1'b0,
                   4'd5, 4'd7, 2'd2, 1'b1, 1'b0, 32'h220, 32'h0, 1'b1);
      tv[13] = mkv(1'b1, 32'h300, 32'h0, 1'b1, 4'd7, 1'b0, 1'b1,
                   4'd5, 4'd7, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      tv[14] = mkv(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0,
                   4'd5, 4'd7, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
      tv[15] = mkv(1'b1, 32'h400, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0,
                   4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 32'h400, 32'h0, 1'b0);
      tv[16] = mkv(1'b1, 32'h404, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0,
                   4'd0, 4'd0, 2'd1, 1'b1, 1'b1, 32'h404, 32'h0, 1'b0);
      tv[17] = mkv(1'b0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b1, 1'b0,
                   4'd0, 4'd0, 2'd0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);

      // ---- reset state ----
      reset = 1'b0;
      idle_in();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", PW'(u_in.ready), PW'(1'b1));
      chk("rst_out_valid", PW'(u_out.valid), PW'(1'b0));
      chk("rst_out_data", u_out.data, '0);
      chk("rst_count", PW'(count), PW'(2'd0));
      chk("rst_raw_hit", PW'(raw_hit), PW'(1'b0));
      @(negedge clk);
      reset = 1'b1;

      // ---- vector table ----
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         u_in.valid  = tv[i].iv;
         u_in.data   = mk(tv[i].pc, tv[i].rd, tv[i].we, tv[i].wa);
         u_out.ready = tv[i].ordy;
         flush       = tv[i].fl;
         rs1_addr    = tv[i].r1;
         rs2_addr    = tv[i].r2;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_count", i), PW'(count), PW'(tv[i].e_cnt));
         chk($sformatf("v%0d_out_valid", i), PW'(u_out.valid), PW'(tv[i].e_ov));
         chk($sformatf("v%0d_in_ready", i), PW'(u_in.ready), PW'(tv[i].e_ir));
         chk($sformatf("v%0d_pc", i), PW'(u_out.data[256:225]), PW'(tv[i].e_pc));
         chk($sformatf("v%0d_rdata", i), PW'(u_out.data[64:33]), PW'(tv[i].e_rd));
         chk($sformatf("v%0d_raw_hit", i), PW'(raw_hit), PW'(tv[i].e_hit));
      end

      // ---- steady stream of 8 with out_ready=1 ----
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         idle_in();
         u_in.valid  = 1'b1;
         u_in.data   = mk(32'h500 + 32'(k * 4), 32'h0, 1'b0, 4'd0);
         u_out.ready = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("stream%0d_count", k), PW'(count), PW'(2'd1));
         chk($sformatf("stream%0d_pc", k), PW'(u_out.data[256:225]),
             PW'(32'h500 + 32'(k * 4)));
      end
      @(negedge clk);
      idle_in();
      u_out.ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stream_drain_count", PW'(count), PW'(2'd0));

      // ---- async reset mid-stream ----
      @(negedge clk);
      idle_in();
      u_in.valid = 1'b1;
      u_in.data  = mk(32'h600, 32'h1234, 1'b1, 4'd3);
      @(posedge clk);
      #1;
      chk("pre_rst_count", PW'(count), PW'(2'd1));
      @(negedge clk);
      idle_in();
      rs1_addr = 4'd3;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_out_valid", PW'(u_out.valid), PW'(1'b0));
      chk("arst_out_data", u_out.data, '0);
      chk("arst_in_ready", PW'(u_in.ready), PW'(1'b1));
      chk("arst_count", PW'(count), PW'(2'd0));
      chk("arst_raw_hit", PW'(raw_hit), PW'(1'b0));
      @(negedge clk);
      reset = 1'b1;
      rs1_addr = 4'd0;
      u_in.valid  = 1'b1;
      u_in.data   = mk(32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 4'd0);
      u_out.ready = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_count", PW'(count), PW'(2'd1));
      chk("post_rst_data", u_out.data, mk(32'h8000_0000, 32'hDEAD_BEEF, 1'b0, 4'd0));
      @(negedge clk);
      u_in.valid = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_pop_count", PW'(count), PW'(2'd0));

      // ---- randomized traffic vs queue model ----
      q.delete();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         u_in.valid  = 1'($urandom_range(0, 1));
         u_in.data   = rnd_pl();
         u_out.ready = 1'($urandom_range(0, 1));
         flush       = ($urandom_range(0, 15) == 0);
         rs1_addr    = 4'($urandom_range(0, 3));
         rs2_addr    = 4'($urandom_range(0, 3));
         #1;
         e_ir  = (q.size() != 2);
         e_ov  = (q.size() != 0);
         e_od  = e_ov ? q[0] : '0;
         e_hit = 1'b0;
         foreach (q[k])
            if (q[k][22] && (q[k][20:17] != 4'd0) &&
                ((q[k][20:17] == rs1_addr) || (q[k][20:17] == rs2_addr)))
               e_hit = 1'b1;
         chk("rnd_in_ready", PW'(u_in.ready), PW'(e_ir));
         chk("rnd_out_valid", PW'(u_out.valid), PW'(e_ov));
         chk("rnd_out_data", u_out.data, e_od);
         chk("rnd_count", PW'(count), PW'(q.size()));
         chk("rnd_raw_hit", PW'(raw_hit), PW'(e_hit));
         @(posedge clk);
         if (flush) begin
            q.delete();
         end else begin
            pv = u_in.valid && (q.size() != 2);
            pp = u_out.ready && (q.size() != 0);
            if (pp)
               void'(q.pop_front());
            if (pv)
               q.push_back(u_in.data);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
